// File: rtl/mem_burst_master.sv
// mem_burst_master: initiator-side burst controller for a single-port data memory.
//
// Takes one burst command at a time and either streams words out of memory over a
// valid/ready read port or streams words into memory from a valid/ready write port.
// The memory writes synchronously when f_memwrite=1 and reads combinationally.
//
// Ports:
//   clk, rst                      clock, synchronous active-high reset
//   cmd_valid/cmd_ready           command handshake
//   cmd_write, cmd_base, cmd_len  burst direction, first word address, word count
//   rd_data/rd_valid/rd_ready     read stream to the consumer
//   wr_data/wr_valid/wr_ready     write stream from the producer
//   f_memwrite, addr, writedata   memory write enable, address, write data
//   readdata                      memory read data (combinational)
//   done                          one-cycle pulse when a burst completes
//   err                           one-cycle pulse when a command is rejected
//
// Optional feature: define MEM_BOUNDS_CHECK_EN to reject commands whose burst would run
// past MEM_DEPTH words. Without it, addresses wrap modulo 2^ADDR_W and err stays 0.

module mem_burst_master #(
  parameter int unsigned ADDR_W    = 13,
  parameter int unsigned DATA_W    = 32,
  parameter int unsigned LEN_W     = 6,
  parameter int unsigned MEM_DEPTH = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic              cmd_write,
  input  logic [ADDR_W-1:0] cmd_base,
  input  logic [LEN_W-1:0]  cmd_len,
  output logic [DATA_W-1:0] rd_data,
  output logic              rd_valid,
  input  logic              rd_ready,
  input  logic [DATA_W-1:0] wr_data,
  input  logic              wr_valid,
  output logic              wr_ready,
  output logic              f_memwrite,
  output logic [ADDR_W-1:0] addr,
  output logic [DATA_W-1:0] writedata,
  input  logic [DATA_W-1:0] readdata,
  output logic              done,
  output logic              err
);

  typedef enum logic [1:0] {StIdle, StRead, StDrain, StWrite} state_e;

  state_e              state_q;
  logic [ADDR_W-1:0]   ptr_q;
  logic [LEN_W-1:0]    cnt_q;
  logic [DATA_W-1:0]   rd_data_q;
  logic                rd_valid_q;
  logic                done_q;
  logic                err_q;

  logic [ADDR_W:0]     burst_end;
  logic                bounds_bad;
  logic                reject;
  logic                rd_free;
  logic                last;

  // One extra bit so base+len never wraps when compared against the depth.
  always_comb begin
    burst_end  = {1'b0, cmd_base} + (ADDR_W + 1)'(cmd_len);
    bounds_bad = (cmd_len != '0) && (burst_end > (ADDR_W + 1)'(MEM_DEPTH));
  end

`ifdef MEM_BOUNDS_CHECK_EN
  assign reject = bounds_bad;
`else
  logic unused_bounds;
  assign unused_bounds = bounds_bad;
  assign reject        = 1'b0;
`endif

  // Output register can take a new word when empty or being emptied this cycle.
  assign rd_free = !rd_valid_q || rd_ready;
  assign last    = (cnt_q == LEN_W'(1));

  assign cmd_ready  = (state_q == StIdle);
  assign wr_ready   = (state_q == StWrite);
  // Gated by rst so a reset cycle never lands a write at the same edge.
  assign f_memwrite = (state_q == StWrite) && wr_valid && !rst;
  assign writedata  = wr_data;
  assign addr       = ptr_q;
  assign rd_data    = rd_data_q;
  assign rd_valid   = rd_valid_q;
  assign done       = done_q;
  assign err        = err_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= StIdle;
      ptr_q      <= '0;
      cnt_q      <= '0;
      rd_data_q  <= '0;
      rd_valid_q <= 1'b0;
      done_q     <= 1'b0;
      err_q      <= 1'b0;
    end else begin
      done_q <= 1'b0;
      err_q  <= 1'b0;
      unique case (state_q)
        StIdle: begin
          if (cmd_valid) begin
            if (reject) begin
              err_q <= 1'b1;
            end else begin
              ptr_q <= cmd_base;
              cnt_q <= cmd_len;
              if (cmd_len == '0) begin
                done_q <= 1'b1;
              end else if (cmd_write) begin
                state_q <= StWrite;
              end else begin
                state_q <= StRead;
              end
            end
          end
        end
        StRead: begin
          if (rd_free) begin
            rd_data_q  <= readdata;
            rd_valid_q <= 1'b1;
            ptr_q      <= ptr_q + 1'b1;
            cnt_q      <= cnt_q - 1'b1;
            if (last) state_q <= StDrain;
          end
        end
        StDrain: begin
          if (rd_valid_q && rd_ready) begin
            rd_valid_q <= 1'b0;
            done_q     <= 1'b1;
            state_q    <= StIdle;
          end
        end
        StWrite: begin
          if (wr_valid) begin
            ptr_q <= ptr_q + 1'b1;
            cnt_q <= cnt_q - 1'b1;
            if (last) begin
              done_q  <= 1'b1;
              state_q <= StIdle;
            end
          end
        end
      endcase
    end
  end

endmodule
